fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter + instruction register stage for the 8-bit multicycle CPU.
//  Drives the instruction memory address and latches the fetched word.
//  Decodes fields for the control FSM and datapath, resolves branches/jumps, and halts on HLT.
//  Controlled by the FSM strobes pc_write / ir_write; sits between instruction memory and the FSM.
// PARAMETERS
//  PC_WIDTH     8      program counter / imem address width
//  INSTR_WIDTH  16     instruction word width
//  RESET_PC     8'h00  PC value after reset
//  CNT_WIDTH    16     retired-instruction counter width (PERF_CNT_EN only)
// PORTS
//  clk          in   1            system clock, all state on rising edge
//  rst          in   1            synchronous, active-high reset
//  pc_write     in   1            FSM strobe: commit next PC (WRITEBACK)
//  ir_write     in   1            FSM strobe: latch imem_rdata into IR (FETCH)
//  imem_rdata   in   INSTR_WIDTH  asynchronous-read instruction memory data at imem_addr
//  alu_zero     in   1            ALU zero flag, valid while pc_write is high
//  alu_neg      in   1            ALU negative flag (a<b), valid while pc_write is high
//  imem_addr    out  PC_WIDTH     = pc register
//  pc           out  PC_WIDTH     current PC
//  opcode       out  4            IR[15:12]
//  rd           out  2            IR[11:10]
//  rs           out  2            IR[9:8]
//  imm          out  8            IR[7:0]
//  branch_taken out  1            combinational: current opcode/flags select a non-sequential PC
//  halted       out  1            sticky halt indication
//  instr_count  out  CNT_WIDTH    retired instructions (PERF_CNT_EN only)
// BEHAVIOUR
//  Reset (sync, overrides everything incl. mid-instruction): pc=RESET_PC, ir=16'h0000, halted=0, instr_count=0.
//  ir_write & !halted: ir <= imem_rdata at the same edge; decoded outputs change the cycle after.
//  pc_write & !halted: pc <= next_pc, one-edge latency.
//   JUMP(9): imm.
//   BEQ(5) & alu_zero / BNE(6) & !alu_zero / BLT(F) & alu_neg: pc+1+$signed(imm).
//   HLT(D): pc unchanged, halted<=1.
//   Otherwise (incl. untaken branch): pc+1.
//  Arithmetic is modulo 2^PC_WIDTH: 8'hFF+1 -> 8'h00; 8'h02+1+8'hFC -> 8'hFF.
//  branch_taken = 1 only for a taken BEQ/BNE/BLT or a JUMP; independent of pc_write.
//  pc_write and ir_write in the same cycle: IR latches the word at the OLD pc; PC updates normally.
//  halted=1: pc and ir are frozen, strobes ignored, and the state is left only via rst.
//  No strobe: all registers hold.
// CONFIGURATION
//  PERF_CNT_EN defined: instr_count increments on every pc_write & !halted (HLT counts once), wraps at 2^CNT_WIDTH.
//  PERF_CNT_EN undefined: the instr_count port and counter logic are absent.
// STRUCTURE
//  cpu_pkg: opcode constants (addi..blt, shared with control FSM), IR field bit positions, INSTR_WIDTH.
//  Sub-module branch_resolve: combinational (opcode, imm, pc, flags) -> next_pc, branch_taken, is_halt.
//  Top level: pc, ir, halted and counter registers plus field slicing.
// TESTING
//  Reset then 3x(ir_write; pc_write) of ADD words -> pc 00->01->02->03, opcode=1 after each ir_write.
//  pc=8'h10, BEQ imm=8'hFC, alu_zero=1, pc_write -> pc=8'h0D, branch_taken=1; alu_zero=0 -> pc=8'h11.
//  JUMP imm=8'h40 -> pc=8'h40; pc=8'hFF, ADD, pc_write -> pc=8'h00 (wrap).
//  HLT at pc=8'h22, pc_write -> halted=1, pc=8'h22; further strobes leave pc and ir unchanged.
//  Assert rst with halted=1 or between ir_write and pc_write -> next cycle pc=RESET_PC, ir=0, halted=0.
//  PERF_CNT_EN: 5 retired instructions + HLT -> instr_count=6, no increment while halted.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// cpu_pkg: shared definitions for the 8-bit multicycle CPU.
//   - opcode_e: instruction opcodes, shared by the fetch unit and the control FSM
//   - IR field positions and widths used to slice the instruction register
//   - INSTR_WORD_WIDTH: instruction word width
package cpu_pkg;

    localparam int unsigned INSTR_WORD_WIDTH = 16;

    // IR field layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
    localparam int unsigned OPCODE_LSB   = 12;
    localparam int unsigned OPCODE_WIDTH = 4;
    localparam int unsigned RD_LSB       = 10;
    localparam int unsigned RS_LSB       = 8;
    localparam int unsigned REG_WIDTH    = 2;
    localparam int unsigned IMM_LSB      = 0;
    localparam int unsigned IMM_WIDTH    = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_BEQ  = 4'h5,
        OP_BNE  = 4'h6,
        OP_LD   = 4'h7,
        OP_ST   = 4'h8,
        OP_JUMP = 4'h9,
        OP_ADDI = 4'hA,
        OP_LI   = 4'hB,
        OP_SLT  = 4'hC,
        OP_HLT  = 4'hD,
        OP_MOV  = 4'hE,
        OP_BLT  = 4'hF
    } opcode_e;

endpackage

// File: rtl/fetch_unit_branch_resolve.sv
// branch_resolve: combinational next-PC selection for the fetch unit.
// Ports:
//   opcode        in   4          decoded opcode of the current IR
//   imm           in   8          immediate field (jump target / signed branch offset)
//   pc            in   PC_WIDTH   current program counter
//   alu_zero      in   1          ALU zero flag
//   alu_neg       in   1          ALU negative flag (a<b)
//   next_pc       out  PC_WIDTH   PC to commit on pc_write
//   branch_taken  out  1          JUMP or taken BEQ/BNE/BLT
//   is_halt       out  1          current opcode is HLT
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 8
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [IMM_WIDTH-1:0]    imm,
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic                    alu_zero,
    input  logic                    alu_neg,
    output logic [PC_WIDTH-1:0]     next_pc,
    output logic                    branch_taken,
    output logic                    is_halt
);

    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] rel_pc;

    // Relative target: pc+1 plus sign-extended offset, modulo 2^PC_WIDTH.
    assign seq_pc = pc + PC_WIDTH'(1);
    assign rel_pc = seq_pc + PC_WIDTH'($signed(imm));

    always_comb begin
        next_pc      = seq_pc;
        branch_taken = 1'b0;
        is_halt      = 1'b0;
        case (opcode)
            OP_JUMP: begin
                next_pc      = PC_WIDTH'(imm);
                branch_taken = 1'b1;
            end
            OP_BEQ: begin
                if (alu_zero) begin
                    next_pc      = rel_pc;
                    branch_taken = 1'b1;
                end
            end
            OP_BNE: begin
                if (!alu_zero) begin
                    next_pc      = rel_pc;
                    branch_taken = 1'b1;
                end
            end
            OP_BLT: begin
                if (alu_neg) begin
                    next_pc      = rel_pc;
                    branch_taken = 1'b1;
                end
            end
            OP_HLT: begin
                next_pc = pc;
                is_halt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction register stage of the 8-bit
// multicycle CPU. Drives the instruction memory address, latches the fetched
// word on ir_write, commits the resolved next PC on pc_write and halts on HLT.
// Optional feature macro: PERF_CNT_EN adds the retired-instruction counter
// (instr_count port and CNT_WIDTH parameter).
// Ports:
//   clk           in   1            clock, rising edge
//   rst           in   1            synchronous active-high reset
//   pc_write      in   1            commit next PC
//   ir_write      in   1            latch imem_rdata into IR
//   imem_rdata    in   INSTR_WIDTH  instruction memory read data at imem_addr
//   alu_zero      in   1            ALU zero flag
//   alu_neg       in   1            ALU negative flag
//   imem_addr     out  PC_WIDTH     instruction memory address (= pc)
//   pc            out  PC_WIDTH     current PC
//   opcode        out  4            IR[15:12]
//   rd            out  2            IR[11:10]
//   rs            out  2            IR[9:8]
//   imm           out  8            IR[7:0]
//   branch_taken  out  1            current opcode/flags select a non-sequential PC
//   halted        out  1            sticky halt
//   instr_count   out  CNT_WIDTH    retired instructions (PERF_CNT_EN only)
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = 8,
    parameter int unsigned          INSTR_WIDTH = INSTR_WORD_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
`ifdef PERF_CNT_EN
    ,
    parameter int unsigned          CNT_WIDTH   = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pc_write,
    input  logic                    ir_write,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata,
    input  logic                    alu_zero,
    input  logic                    alu_neg,
    output logic [PC_WIDTH-1:0]     imem_addr,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [3:0]              opcode,
    output logic [1:0]              rd,
    output logic [1:0]              rs,
    output logic [7:0]              imm,
    output logic                    branch_taken,
    output logic                    halted
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]    instr_count
`endif
);

    logic [PC_WIDTH-1:0]    pc_q;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic                   halted_q;
    logic [PC_WIDTH-1:0]    next_pc;
    logic                   is_halt;
    logic                   pc_commit;

    assign pc_commit = pc_write && !halted_q;

    assign opcode    = ir_q[OPCODE_LSB +: OPCODE_WIDTH];
    assign rd        = ir_q[RD_LSB +: REG_WIDTH];
    assign rs        = ir_q[RS_LSB +: REG_WIDTH];
    assign imm       = ir_q[IMM_LSB +: IMM_WIDTH];
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign halted    = halted_q;

    branch_resolve #(
        .PC_WIDTH (PC_WIDTH)
    ) u_branch_resolve (
        .opcode       (opcode),
        .imm          (imm),
        .pc           (pc_q),
        .alu_zero     (alu_zero),
        .alu_neg      (alu_neg),
        .next_pc      (next_pc),
        .branch_taken (branch_taken),
        .is_halt      (is_halt)
    );

    // IR and PC may be written in the same edge: IR captures the word at the
    // old PC while the PC advances using the previous IR's decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (ir_write) begin
                ir_q <= imem_rdata;
            end
            if (pc_write) begin
                pc_q <= next_pc;
                if (is_halt) begin
                    halted_q <= 1'b1;
                end
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] count_q;

    // HLT retires once: the halting commit still counts, later strobes do not.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (pc_commit) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        ir_write;
    logic [15:0] imem_rdata;
    logic        alu_zero;
    logic        alu_neg;
    logic [7:0]  imem_addr;
    logic [7:0]  pc;
    logic [3:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
    logic        branch_taken;
    logic        halted;
`ifdef PERF_CNT_EN
    logic [15:0] instr_count;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (16),
        .RESET_PC    (8'h00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .imem_rdata   (imem_rdata),
        .alu_zero     (alu_zero),
        .alu_neg      (alu_neg),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .opcode       (opcode),
        .rd           (rd),
        .rs           (rs),
        .imm          (imm),
        .branch_taken (branch_taken),
        .halted       (halted)
`ifdef PERF_CNT_EN
        ,
        .instr_count  (instr_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] word);
        imem_rdata = word;
        ir_write   = 1'b1;
        tick();
        ir_write   = 1'b0;
    endtask

    task automatic commit_pc();
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        imem_rdata = 16'h0000;
        alu_zero   = 1'b0;
        alu_neg    = 1'b0;
        tick();
        rst = 1'b0;

        chk("reset_pc", pc, 8'h00);
        chk("reset_addr", imem_addr, 8'h00);
        chk("reset_opcode", opcode, 4'h0);
        chk("reset_imm", imm, 8'h00);
        chk("reset_halted", halted, 1'b0);
        chk("reset_bt", branch_taken, 1'b0);
`ifdef PERF_CNT_EN
        chk("reset_count", instr_count, 16'd0);
`endif

        // Three sequential ADDs
        load_ir(16'h1A05);
        chk("add0_opcode", opcode, 4'h1);
        chk("add0_rd", rd, 2'd2);
        chk("add0_rs", rs, 2'd2);
        chk("add0_imm", imm, 8'h05);
        commit_pc();
        chk("add0_pc", pc, 8'h01);
        load_ir(16'h1A05);
        chk("add1_opcode", opcode, 4'h1);
        commit_pc();
        chk("add1_pc", pc, 8'h02);
        load_ir(16'h1A05);
        chk("add2_opcode", opcode, 4'h1);
        commit_pc();
        chk("add2_pc", pc, 8'h03);
        chk("add2_addr", imem_addr, 8'h03);

        // JUMP to 0x10
        load_ir(16'h9010);
        chk("jump10_bt", branch_taken, 1'b1);
        commit_pc();
        chk("jump10_pc", pc, 8'h10);

        // BEQ taken, backwards offset -4: 0x10+1-4 = 0x0D
        alu_zero = 1'b1;
        load_ir(16'h50FC);
        chk("beq_taken_bt", branch_taken, 1'b1);
        commit_pc();
        chk("beq_taken_pc", pc, 8'h0D);
        alu_zero = 1'b0;

        load_ir(16'h9010);
        commit_pc();
        chk("jump10b_pc", pc, 8'h10);

        // BEQ untaken
        load_ir(16'h50FC);
        chk("beq_untaken_bt", branch_taken, 1'b0);
        commit_pc();
        chk("beq_untaken_pc", pc, 8'h11);

        // BNE taken (zero=0): 0x11+1+5 = 0x17
        load_ir(16'h6005);
        chk("bne_taken_bt", branch_taken, 1'b1);
        alu_zero = 1'b1;
        #1;
        chk("bne_untaken_bt", branch_taken, 1'b0);
        alu_zero = 1'b0;
        commit_pc();
        chk("bne_taken_pc", pc, 8'h17);

        // BLT taken: 0x17+1+2 = 0x1A, then untaken -> 0x1B
        alu_neg = 1'b1;
        load_ir(16'hF002);
        chk("blt_taken_bt", branch_taken, 1'b1);
        commit_pc();
        chk("blt_taken_pc", pc, 8'h1A);
        alu_neg = 1'b0;
        #1;
        chk("blt_untaken_bt", branch_taken, 1'b0);
        commit_pc();
        chk("blt_untaken_pc", pc, 8'h1B);

        // Modulo arithmetic: 0x02+1+0xFC = 0xFF, then 0xFF+1 = 0x00
        load_ir(16'h9002);
        commit_pc();
        chk("jump02_pc", pc, 8'h02);
        alu_zero = 1'b1;
        load_ir(16'h50FC);
        commit_pc();
        chk("beq_wrap_pc", pc, 8'hFF);
        alu_zero = 1'b0;
        load_ir(16'h1000);
        commit_pc();
        chk("add_wrap_pc", pc, 8'h00);

        // Simultaneous strobes: IR takes new word, PC advances by old IR (ADD)
        imem_rdata = 16'h9077;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        tick();
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        chk("both_pc", pc, 8'h01);
        chk("both_opcode", opcode, 4'h9);
        chk("both_imm", imm, 8'h77);
        commit_pc();
        chk("both_jump_pc", pc, 8'h77);

        // No strobes: hold
        imem_rdata = 16'h1111;
        tick();
        tick();
        tick();
        chk("hold_pc", pc, 8'h77);
        chk("hold_opcode", opcode, 4'h9);

        // HLT at 0x22
        load_ir(16'h9022);
        commit_pc();
        chk("jump22_pc", pc, 8'h22);
        load_ir(16'hD000);
        chk("hlt_bt", branch_taken, 1'b0);
        chk("hlt_pre_halted", halted, 1'b0);
        commit_pc();
        chk("hlt_halted", halted, 1'b1);
        chk("hlt_pc", pc, 8'h22);
        imem_rdata = 16'h1234;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        tick();
        tick();
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        chk("halt_frozen_pc", pc, 8'h22);
        chk("halt_frozen_opcode", opcode, 4'hD);
        chk("halt_frozen_imm", imm, 8'h00);
        chk("halt_sticky", halted, 1'b1);

        // Reset while halted
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_halt_pc", pc, 8'h00);
        chk("rst_halt_opcode", opcode, 4'h0);
        chk("rst_halt_halted", halted, 1'b0);

        // Reset between ir_write and pc_write; reset beats pc_write
        load_ir(16'h9055);
        chk("mid_opcode", opcode, 4'h9);
        rst      = 1'b1;
        pc_write = 1'b1;
        tick();
        rst      = 1'b0;
        pc_write = 1'b0;
        chk("rst_mid_pc", pc, 8'h00);
        chk("rst_mid_opcode", opcode, 4'h0);
        chk("rst_mid_imm", imm, 8'h00);
        chk("rst_mid_halted", halted, 1'b0);
`ifdef PERF_CNT_EN
        chk("rst_mid_count", instr_count, 16'd0);
`endif

        // Five ADDs then HLT: six retired instructions
        for (int i = 0; i < 5; i++) begin
            load_ir(16'h1000);
            commit_pc();
        end
        chk("five_add_pc", pc, 8'h05);
        load_ir(16'hD000);
        commit_pc();
        chk("final_halted", halted, 1'b1);
        chk("final_pc", pc, 8'h05);
`ifdef PERF_CNT_EN
        chk("count_after_hlt", instr_count, 16'd6);
        commit_pc();
        commit_pc();
        chk("count_while_halted", instr_count, 16'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
